// File: rtl/rr_interval.sv
// rtl/rr_interval.sv - RR interval tracker with 4-interval averaged heart-rate divider
module rr_interval #(
  parameter int FS      = 360,
  parameter int REFRACT = 72,
  parameter int MAX_RR  = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r_peak,
  output logic [11:0] rr,
  output logic        rr_valid,
  output logic [7:0]  bpm,
  output logic        bpm_valid,
  output logic        no_beat
);

  localparam logic [14:0] DIVIDEND  = 15'(60 * FS);
  localparam logic [11:0] REFRACT_C = 12'(REFRACT);
  localparam logic [11:0] MAX_RR_C  = 12'(MAX_RR);

  typedef enum logic       {ACQ, TRACK} trk_state_t;
  typedef enum logic [1:0] {D_IDLE, D_BUSY, D_DONE} div_state_t;

  trk_state_t  trk_state, trk_state_n;
  div_state_t  div_state, div_state_n;

  logic        r_prev, armed, peak_event;
  logic        acq_load, accept, timeout;
  logic [11:0] cnt;
  logic [11:0] hist [4];
  logic [1:0]  hist_wr;
  logic [2:0]  hist_cnt;
  logic [13:0] sum;

  logic        div_start, div_last, q_bit;
  logic [3:0]  iter;
  logic [14:0] quo, quo_n;
  logic [11:0] rem, rem_n, divisor;
  logic [12:0] rem_sh;

  // armed stays low until r_peak has been seen low, so a level held across reset is not an event
  assign peak_event = r_peak && !r_prev && armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 1'b0;
      armed  <= 1'b0;
    end else begin
      r_prev <= r_peak;
      if (!r_peak) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) trk_state <= ACQ;
    else     trk_state <= trk_state_n;
  end

  always_comb begin
    trk_state_n = trk_state;
    case (trk_state)
      ACQ:     if (peak_event) trk_state_n = TRACK;
      TRACK:   if (timeout) trk_state_n = ACQ;
      default: trk_state_n = ACQ;
    endcase
  end

  // An event coinciding with the timeout wins because cnt == MAX_RR already clears the refractory test
  always_comb begin
    acq_load = 1'b0;
    accept   = 1'b0;
    timeout  = 1'b0;
    case (trk_state)
      ACQ:   acq_load = peak_event;
      TRACK: begin
        accept  = peak_event && (cnt >= REFRACT_C);
        timeout = !accept && (cnt >= MAX_RR_C);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      rr       <= '0;
      rr_valid <= 1'b0;
      no_beat  <= 1'b0;
      hist_wr  <= '0;
      hist_cnt <= '0;
      sum      <= '0;
      for (int i = 0; i < 4; i++) hist[i] <= '0;
    end else begin
      rr_valid <= accept;
      if (acq_load) begin
        cnt     <= 12'd1;
        no_beat <= 1'b0;
      end else if (accept) begin
        cnt           <= 12'd1;
        rr            <= cnt;
        hist[hist_wr] <= cnt;
        hist_wr       <= hist_wr + 2'd1;
        sum           <= sum + {2'b00, cnt} - {2'b00, hist[hist_wr]};
        if (hist_cnt != 3'd4) hist_cnt <= hist_cnt + 3'd1;
      end else if (timeout) begin
        cnt      <= '0;
        no_beat  <= 1'b1;
        hist_wr  <= '0;
        hist_cnt <= '0;
        sum      <= '0;
        for (int i = 0; i < 4; i++) hist[i] <= '0;
      end else if (trk_state == TRACK && cnt < MAX_RR_C) begin
        cnt <= cnt + 12'd1;
      end
    end
  end

  assign div_start = rr_valid && (hist_cnt == 3'd4);

  always_ff @(posedge clk) begin
    if (rst) div_state <= D_IDLE;
    else     div_state <= div_state_n;
  end

  always_comb begin
    div_state_n = div_state;
    if (timeout) begin
      div_state_n = D_IDLE;
    end else begin
      case (div_state)
        D_IDLE:  if (div_start) div_state_n = D_BUSY;
        D_BUSY:  if (iter == 4'd14) div_state_n = D_DONE;
        D_DONE:  div_state_n = D_IDLE;
        default: div_state_n = D_IDLE;
      endcase
    end
  end

  always_comb begin
    bpm_valid = (div_state == D_DONE);
    div_last  = (div_state == D_BUSY) && (iter == 4'd14);
  end

  // One restoring step: dividend bits leave quo's MSB as quotient bits enter its LSB
  always_comb begin
    rem_sh = {rem, quo[14]};
    q_bit  = (rem_sh >= {1'b0, divisor});
    rem_n  = q_bit ? 12'(rem_sh - {1'b0, divisor}) : rem_sh[11:0];
    quo_n  = {quo[13:0], q_bit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iter    <= '0;
      quo     <= '0;
      rem     <= '0;
      divisor <= '0;
      bpm     <= '0;
    end else if (timeout) begin
      bpm <= '0;
    end else if (div_state == D_IDLE && div_start) begin
      iter    <= '0;
      quo     <= DIVIDEND;
      rem     <= '0;
      divisor <= sum[13:2];
    end else if (div_state == D_BUSY) begin
      iter <= iter + 4'd1;
      quo  <= quo_n;
      rem  <= rem_n;
      if (div_last) bpm <= (quo_n > 15'd255) ? 8'hFF : quo_n[7:0];
    end
  end

endmodule

// File: tb/tb_rr_interval.sv
// tb/tb_rr_interval.sv - self-checking bench for rr_interval: vector table, corner sequences, random vs model
module tb_rr_interval;

  localparam int FS      = 360;
  localparam int REFRACT = 72;
  localparam int MAX_RR  = 4095;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r_peak = 1'b0;
  logic [11:0] rr;
  logic        rr_valid;
  logic [7:0]  bpm;
  logic        bpm_valid;
  logic        no_beat;

  rr_interval dut (
    .clk(clk), .rst(rst), .r_peak(r_peak), .rr(rr), .rr_valid(rr_valid),
    .bpm(bpm), .bpm_valid(bpm_valid), .no_beat(no_beat)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: event times as edge numbers, intervals as differences, history as a queue
  int k = 0;
  bit m_seen_low = 0, m_last_v = 0, m_track = 0;
  int m_last_acc = 0;
  int m_hist[$];
  int m_bpm_due = -1, m_bpm_next = 0;
  int e_rr = 0, e_bpm = 0;
  bit e_rrv = 0, e_bpv = 0, e_nb = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit v, input bit r);
    bit ev;
    int d, s;
    k++;
    e_rrv = 0;
    e_bpv = 0;
    if (r) begin
      e_rr = 0; e_bpm = 0; e_nb = 0;
      m_track = 0; m_hist.delete(); m_bpm_due = -1;
      m_seen_low = 0; m_last_v = 0;
      return;
    end
    ev = v && !m_last_v && m_seen_low;
    m_last_v = v;
    if (!v) m_seen_low = 1;
    if (m_bpm_due == k) begin
      e_bpv = 1;
      e_bpm = m_bpm_next;
      m_bpm_due = -1;
    end
    if (!m_track) begin
      if (ev) begin
        m_track = 1;
        m_last_acc = k;
        e_nb = 0;
      end
    end else begin
      d = k - m_last_acc;
      if (ev && d >= REFRACT) begin
        e_rr = d;
        e_rrv = 1;
        m_last_acc = k;
        m_hist.push_back(d);
        if (m_hist.size() > 4) void'(m_hist.pop_front());
        if (m_hist.size() == 4) begin
          s = m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3];
          m_bpm_next = (60 * FS) / (s / 4);
          if (m_bpm_next > 255) m_bpm_next = 255;
          m_bpm_due = k + 16;
        end
      end else if (d >= MAX_RR) begin
        m_track = 0;
        e_nb = 1;
        m_hist.delete();
        e_bpm = 0;
        m_bpm_due = -1;
      end
    end
  endtask

  task automatic check_cycle();
    n_cmp++;
    if ({rr, rr_valid, bpm, bpm_valid, no_beat} !== {12'(e_rr), e_rrv, 8'(e_bpm), e_bpv, e_nb}) begin
      n_fail++;
      $display("FAIL cycle %0d outputs: got rr=%0d rr_valid=%0b bpm=%0d bpm_valid=%0b no_beat=%0b, expected rr=%0d rr_valid=%0b bpm=%0d bpm_valid=%0b no_beat=%0b",
               k, rr, rr_valid, bpm, bpm_valid, no_beat, e_rr, e_rrv, e_bpm, e_bpv, e_nb);
    end
  endtask

  task automatic tick(input bit v);
    r_peak = v;
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_edge(v, 1'b0);
    check_cycle();
  endtask

  task automatic tick_rst(input bit v);
    r_peak = v;
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_edge(v, 1'b1);
    check_cycle();
  endtask

  typedef struct {
    int gap;    // cycles from this row's rising edge to the next row's
    int width;  // cycles r_peak is held high
    int acc;    // rr_valid pulses expected in the row
    int rr;     // rr at end of row
    int bpv;    // bpm_valid pulses expected in the row
    int bpm;    // bpm at end of row
  } row_t;

  row_t tbl[16];

  initial begin
    int acc, bpv, n_to, early, late, rrv_cnt;

    tbl[0]  = '{360, 1,  0,   0, 0,   0};
    tbl[1]  = '{360, 1,  1, 360, 0,   0};
    tbl[2]  = '{360, 1,  1, 360, 0,   0};
    tbl[3]  = '{360, 1,  1, 360, 0,   0};
    tbl[4]  = '{300, 1,  1, 360, 1,  60};
    tbl[5]  = '{300, 1,  1, 300, 1,  62};
    tbl[6]  = '{300, 1,  1, 300, 1,  65};
    tbl[7]  = '{300, 1,  1, 300, 1,  68};
    tbl[8]  = '{200, 1,  1, 300, 1,  72};
    tbl[9]  = '{ 50, 1,  1, 200, 1,  78};
    tbl[10] = '{310, 1,  0, 200, 0,  78};
    tbl[11] = '{ 80, 1,  1, 360, 1,  74};
    tbl[12] = '{ 80, 20, 1,  80, 1,  91};
    tbl[13] = '{ 80, 20, 1,  80, 1, 120};
    tbl[14] = '{ 80, 20, 1,  80, 1, 144};
    tbl[15] = '{ 80, 20, 1,  80, 1, 255};

    for (int i = 0; i < 3; i++) tick_rst(1'b0);
    chk("reset_rr", int'(rr), 0);
    chk("reset_bpm", int'(bpm), 0);
    chk("reset_rr_valid", int'(rr_valid), 0);
    chk("reset_bpm_valid", int'(bpm_valid), 0);
    chk("reset_no_beat", int'(no_beat), 0);
    for (int i = 0; i < 4; i++) tick(1'b0);

    for (int r = 0; r < 16; r++) begin
      acc = 0;
      bpv = 0;
      for (int i = 0; i < tbl[r].gap; i++) begin
        tick(i < tbl[r].width);
        if (rr_valid) acc++;
        if (bpm_valid) bpv++;
      end
      chk($sformatf("row%0d_rr_valid_count", r), acc, tbl[r].acc);
      chk($sformatf("row%0d_rr", r), int'(rr), tbl[r].rr);
      chk($sformatf("row%0d_bpm_valid_count", r), bpv, tbl[r].bpv);
      chk($sformatf("row%0d_bpm", r), int'(bpm), tbl[r].bpm);
    end

    // No beat: last accepted peak was 80 cycles ago, timeout lands 4095 after it
    n_to = -1;
    for (int j = 1; j <= 4200; j++) begin
      tick(1'b0);
      if (no_beat) begin
        n_to = j;
        break;
      end
    end
    chk("timeout_cycles", n_to, MAX_RR - 80 + 1);
    chk("timeout_bpm", int'(bpm), 0);

    tick(1'b1);
    chk("reacq_rr_valid", int'(rr_valid), 0);
    chk("reacq_no_beat", int'(no_beat), 0);
    early = 0;
    late = 0;
    for (int e = 0; e < 4; e++) begin
      for (int i = 0; i < 99; i++) begin
        tick(1'b0);
        if (bpm_valid) early++;
      end
      tick(1'b1);
      if (bpm_valid) begin
        if (e == 3) late++;
        else early++;
      end
    end
    for (int i = 0; i < 20; i++) begin
      tick(1'b0);
      if (bpm_valid) late++;
    end
    chk("refill_bpm_valid_early", early, 0);
    chk("refill_bpm_valid_late", late, 1);
    chk("refill_bpm", int'(bpm), 216);

    // Reset five cycles into a divide
    for (int i = 0; i < 99; i++) tick(1'b0);
    tick(1'b1);
    for (int i = 0; i < 6; i++) tick(1'b0);
    tick_rst(1'b0);
    chk("middiv_rst_rr", int'(rr), 0);
    chk("middiv_rst_bpm", int'(bpm), 0);
    chk("middiv_rst_rr_valid", int'(rr_valid), 0);
    chk("middiv_rst_bpm_valid", int'(bpm_valid), 0);
    chk("middiv_rst_no_beat", int'(no_beat), 0);
    bpv = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1'b0);
      if (bpm_valid) bpv++;
    end
    chk("middiv_rst_no_bpm_valid", bpv, 0);

    // r_peak high across reset release must not count as an event
    for (int i = 0; i < 3; i++) tick_rst(1'b1);
    rrv_cnt = 0;
    for (int i = 0; i < 10; i++) tick(1'b1);
    for (int i = 0; i < 80; i++) tick(1'b0);
    tick(1'b1);
    if (rr_valid) rrv_cnt++;
    for (int i = 0; i < 99; i++) begin
      tick(1'b0);
      if (rr_valid) rrv_cnt++;
    end
    tick(1'b1);
    if (rr_valid) rrv_cnt++;
    chk("held_rst_rr_valid_count", rrv_cnt, 1);
    chk("held_rst_rr", int'(rr), 100);

    // Event exactly at MAX_RR is a normal beat, not a timeout
    for (int i = 0; i < MAX_RR - 1; i++) tick(1'b0);
    tick(1'b1);
    chk("maxrr_rr_valid", int'(rr_valid), 1);
    chk("maxrr_rr", int'(rr), MAX_RR);
    tick(1'b0);
    chk("maxrr_no_beat", int'(no_beat), 0);

    for (int ev = 0; ev < 120; ev++) begin
      int gap, width;
      if (ev % 60 == 59) gap = 4200;
      else if ($urandom_range(3) == 0) gap = $urandom_range(REFRACT + 3, REFRACT - 3);
      else gap = $urandom_range(400, 2);
      width = $urandom_range((gap > 31) ? 30 : gap - 1, 1);
      for (int i = 0; i < gap; i++) begin
        if (i > 0 && $urandom_range(999) == 0) tick_rst(i < width);
        else tick(i < width);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
